// File: rtl/stream_sink_checker_if.sv
// Valid/ready stream bundle between an upstream source and stream_sink_checker.
// The master drives valid/data. The slave (the sink) drives ready.
interface stream_sink_checker_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;

  modport master (output in_valid_i, output in_data_i, input in_ready_o);
  modport slave  (input in_valid_i, input in_data_i, output in_ready_o);
endinterface

// File: rtl/stream_sink_checker.sv
// stream_sink_checker: receive endpoint for the skid-buffer test environment.
// It accepts num_beats_i beats and compares each beat against EXP_DATA.
// It counts beats and data mismatches, and flags source handshake violations.
// Optional feature macro: SINK_BACKPRESSURE_EN. When defined, a 16-bit LFSR
// gates in_ready_o to give pseudo-random backpressure.
module stream_sink_checker #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] EXP_DATA  = 32'hDEADBEEF,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       num_beats_i,
  stream_sink_checker_if.slave   in_if,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [CNT_W-1:0]       beat_cnt_o,
  output logic [CNT_W-1:0]       err_cnt_o,
  output logic [WIDTH-1:0]       first_err_data_o,
  output logic                   proto_err_o
);

  localparam logic [WIDTH-1:0] EXP = WIDTH'(EXP_DATA);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_beats;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] first_err_data;
  logic             proto_err;
  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic             ready;
  logic             start_acc;
  logic             hs;
  logic             last_beat;
  logic             mismatch;

  assign start_acc = start_i && (state != RUN);
  assign hs        = in_if.in_valid_i && ready;
  assign last_beat = hs && (beat_cnt == (num_beats - CNT_W'(1)));
  assign mismatch  = (in_if.in_data_i != EXP);

`ifdef SINK_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11). It is reseeded on every accepted
  // start and advances on every RUN cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lfsr <= LFSR_SEED;
    end else if (start_acc) begin
      lfsr <= LFSR_SEED;
    end else if (state == RUN) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  // Ready depends only on state and the LFSR, never on valid.
  always_comb ready = (state == RUN) && lfsr[0];
`else
  logic unused_seed;

  // Without backpressure the seed has no consumer.
  always_comb unused_seed = ^LFSR_SEED;

  // Ready depends only on state, never on valid.
  always_comb ready = (state == RUN);
`endif

  assign in_if.in_ready_o = ready;

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. A zero-length run skips RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_i) state_nxt = (num_beats_i == '0) ? DONE : RUN;
      RUN:        if (last_beat) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Run bookkeeping: beat and error counting, first-error capture, protocol monitor.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      num_beats      <= '0;
      beat_cnt       <= '0;
      err_cnt        <= '0;
      first_err_data <= '0;
      proto_err      <= 1'b0;
      prev_stall     <= 1'b0;
      prev_data      <= '0;
    end else if (start_acc) begin
      num_beats      <= num_beats_i;
      beat_cnt       <= '0;
      err_cnt        <= '0;
      first_err_data <= '0;
      proto_err      <= 1'b0;
      prev_stall     <= 1'b0;
      prev_data      <= '0;
    end else if (state == RUN) begin
      if (hs) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          if (err_cnt == '0) first_err_data <= in_if.in_data_i;
        end
      end
      prev_stall <= in_if.in_valid_i && !ready;
      prev_data  <= in_if.in_data_i;
      if (prev_stall && (!in_if.in_valid_i || (in_if.in_data_i != prev_data)))
        proto_err <= 1'b1;
    end
  end

  // Status outputs decode registered state only.
  always_comb begin
    busy_o           = (state == RUN);
    done_o           = (state == DONE);
    pass_o           = (state == DONE) && (err_cnt == '0) && !proto_err;
    beat_cnt_o       = beat_cnt;
    err_cnt_o        = err_cnt;
    first_err_data_o = first_err_data;
    proto_err_o      = proto_err;
  end

endmodule

// File: doc/stream_sink_checker.md
# stream_sink_checker

Valid/ready receive endpoint for the skid-buffer test environment. It consumes a fixed number of beats from an upstream source, compares each accepted beat against a constant expected word, and counts beats and mismatches. It also flags source-side handshake violations. It sits at the downstream end of the buffer under test, and can optionally stress it with pseudo-random backpressure.

## Interface
- WIDTH, 32, data bus width
- EXP_DATA, 'hDEADBEEF, expected beat value; truncated or zero-extended to WIDTH
- CNT_W, 16, width of beat/error counters and num_beats_i
- LFSR_SEED, 16'hACE1, backpressure LFSR seed; must be non-zero
- clk  input  1  clock, all logic rising-edge
- arst  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle pulse; begins a run
- num_beats_i  input  CNT_W  beats to accept; sampled only when start_i is accepted
- in_valid_i  input  1  source beat valid
- in_data_i  input  WIDTH  source beat data
- in_ready_o  output  1  sink ready
- busy_o  output  1  high in RUN
- done_o  output  1  high in DONE; sticky until the next accepted start
- pass_o  output  1  in DONE: err_cnt_o==0 and proto_err_o==0; otherwise 0
- beat_cnt_o  output  CNT_W  beats accepted in the current run
- err_cnt_o  output  CNT_W  data mismatches; saturates at all-ones
- first_err_data_o  output  WIDTH  data of the first mismatching beat in the run
- proto_err_o  output  1  sticky; source dropped valid or changed data while stalled

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE or DONE with start_i=1:
  - Latch num_beats_i.
  - Clear beat_cnt, err_cnt, first_err_data and proto_err.
  - Load the LFSR with LFSR_SEED.
  - Go to RUN. If num_beats_i==0, go directly to DONE instead.
- start_i in RUN is ignored.
- Handshake: a beat is accepted when in_valid_i && in_ready_o on a clock edge.
- in_ready_o never depends on in_valid_i. It is 0 outside RUN.
- On each accepted beat:
  - beat_cnt increments.
  - If in_data_i != EXP_DATA[WIDTH-1:0], err_cnt increments (saturating).
  - If this is the first mismatch of the run, first_err_data captures in_data_i.
- RUN → DONE on the edge that accepts beat number num_beats (i.e. when beat_cnt==num_beats-1 and a handshake occurs).
- Protocol check, RUN only:
  - Register the previous cycle's valid && !ready and its data.
  - If that term was set and this cycle has in_valid_i==0 or changed in_data_i, set proto_err.
- Counters are CNT_W bits. beat_cnt cannot exceed num_beats, so it never wraps.
- Reset mid-run: all state returns to reset values immediately (asynchronous). Any in-flight beat is discarded.

## Timing
- All outputs are 0 at reset, except first_err_data_o, which is also 0.
- in_ready_o is combinational from state and LFSR bit 0. All other outputs are registered.
- Counter and flag updates are visible the cycle after the accepting edge.
- done_o and pass_o rise the cycle after the final handshake. busy_o falls in that same cycle.
- start_i to busy_o=1: one cycle. The first beat can be accepted in that cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every RUN cycle, whether or not a handshake occurs.
- Throughput without the backpressure feature: 1 beat/cycle.

## Configuration
- SINK_BACKPRESSURE_EN defined:
  - in_ready_o = (state==RUN) & lfsr[0].
  - Ready toggles pseudo-randomly at about 50% duty.
  - The sequence is deterministic per LFSR_SEED.
- SINK_BACKPRESSURE_EN undefined:
  - in_ready_o = (state==RUN).
  - The LFSR is not instantiated.
  - Protocol checking remains, but it can never fire because ready is never low in RUN.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, in_ready_o=0.
- start_i with num_beats_i=8, source drives 'hDEADBEEF continuously with valid=1 (no backpressure) → 8 beats in 8 cycles; done_o=1, pass_o=1, beat_cnt_o=8, err_cnt_o=0.
- num_beats_i=4, beat 2 = 'h12345678, beats 3–4 = 'h0 → err_cnt_o=3, first_err_data_o='h12345678, pass_o=0.
- With SINK_BACKPRESSURE_EN, num_beats_i=100, compliant source → beat_cnt_o=100, proto_err_o=0, pass_o=1. Ready pattern must match the seed-'hACE1 LFSR reference model.
- With SINK_BACKPRESSURE_EN, source changes data while stalled → proto_err_o=1, pass_o=0 at done.
- arst pulsed after 3 of 8 beats, then new start with num_beats_i=2 → counters restart from 0; done_o with beat_cnt_o=2. num_beats_i=0 → done_o the cycle after start, no ready asserted.
